// File: rtl/camera_pkg.sv
// Shared types and constants for the 2x2 pixel readout capture path.
// READOUT_CHECKSUM_EN adds a fifth XOR-checksum beat to every streamed frame.
package camera_pkg;

    localparam int PIX_W_DEFAULT = 8;
    localparam int N_PIX         = 4;

`ifdef READOUT_CHECKSUM_EN
    localparam int N_BEATS = N_PIX + 1;
`else
    localparam int N_BEATS = N_PIX;
`endif

    typedef enum logic {
        IDLE,
        STREAM
    } stream_state_t;

    typedef logic [2:0] beat_idx_t;

    localparam beat_idx_t LAST_IDX = beat_idx_t'(N_BEATS - 1);

endpackage

// File: rtl/readout_stream_tx.sv
// Streams one captured frame out one pixel per beat on valid/ready.
// With READOUT_CHECKSUM_EN defined, a trailing XOR checksum beat is appended.
module readout_stream_tx
    import camera_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [PIX_W-1:0] frame [N_PIX],
    input  logic             ready,
    output logic             busy,
    output logic [PIX_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    output logic             frame_done
);

    stream_state_t    state;
    beat_idx_t        idx;
    logic [PIX_W-1:0] outbuf [N_BEATS];

`ifdef READOUT_CHECKSUM_EN
    logic [PIX_W-1:0] chk;

    always_comb begin
        chk = '0;
        for (int unsigned i = 0; i < N_PIX; i++) begin
            chk = chk ^ frame[i];
        end
    end
`endif

    assign busy = (state != IDLE);

    // The buffer shifts toward entry 0 on each accepted beat, so the next
    // beat is always outbuf[1] and no variable array index is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            for (int unsigned i = 0; i < N_BEATS; i++) begin
                outbuf[i] <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        for (int unsigned i = 0; i < N_PIX; i++) begin
                            outbuf[i] <= frame[i];
                        end
`ifdef READOUT_CHECKSUM_EN
                        outbuf[N_PIX] <= chk;
`endif
                        out_data  <= frame[0];
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        idx       <= '0;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (ready) begin
                        if (out_last) begin
                            out_valid  <= 1'b0;
                            out_last   <= 1'b0;
                            frame_done <= 1'b1;
                            idx        <= '0;
                            state      <= IDLE;
                        end else begin
                            for (int unsigned i = 0; i < N_BEATS - 1; i++) begin
                                outbuf[i] <= outbuf[i+1];
                            end
                            out_data <= outbuf[1];
                            idx      <= idx + 3'd1;
                            out_last <= ((idx + 3'd1) == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pixel_readout_capture.sv
// Captures the two column ADC codes per row strobe into a 2x2 frame and hands
// complete frames to the stream transmitter. READOUT_CHECKSUM_EN: see readout_stream_tx.
module pixel_readout_capture
    import camera_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             NRE_1,
    input  logic             NRE_2,
    input  logic             ADC,
    input  logic             Erase,
    input  logic [PIX_W-1:0] Pixel_col1,
    input  logic [PIX_W-1:0] Pixel_col2,
    input  logic             Out_ready,
    output logic [PIX_W-1:0] Out_data,
    output logic             Out_valid,
    output logic             Out_last,
    output logic             Frame_done,
    output logic             Sel_err,
    output logic             Overrun
);

    logic             adc_q;
    logic             row1_ok;
    logic             row2_ok;
    logic [PIX_W-1:0] cap [N_PIX];
    logic             adc_edge;
    logic             sel_row1;
    logic             sel_row2;
    logic             both_low;
    logic             complete;
    logic             busy;
    logic             load;

    assign adc_edge = ADC & ~adc_q;
    assign sel_row1 = adc_edge & ~Erase & ~NRE_1 &  NRE_2;
    assign sel_row2 = adc_edge & ~Erase &  NRE_1 & ~NRE_2;
    assign both_low = adc_edge & ~NRE_1 & ~NRE_2;
    assign complete = row1_ok & row2_ok;
    assign load     = complete & ~busy;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            adc_q   <= 1'b0;
            row1_ok <= 1'b0;
            row2_ok <= 1'b0;
            Sel_err <= 1'b0;
            Overrun <= 1'b0;
            for (int unsigned i = 0; i < N_PIX; i++) begin
                cap[i] <= '0;
            end
        end else begin
            adc_q <= ADC;
            if (sel_row1) begin
                cap[0] <= Pixel_col1;
                cap[1] <= Pixel_col2;
            end
            if (sel_row2) begin
                cap[2] <= Pixel_col1;
                cap[3] <= Pixel_col2;
            end
            if (both_low) begin
                Sel_err <= 1'b1;
            end
            if (complete && busy) begin
                Overrun <= 1'b1;
            end
            // A completed frame releases its flags; a row landing on the same
            // edge already belongs to the next frame.
            if (Erase) begin
                row1_ok <= 1'b0;
                row2_ok <= 1'b0;
            end else begin
                if (complete) begin
                    row1_ok <= 1'b0;
                    row2_ok <= 1'b0;
                end
                if (sel_row1) begin
                    row1_ok <= 1'b1;
                end
                if (sel_row2) begin
                    row2_ok <= 1'b1;
                end
            end
        end
    end

    readout_stream_tx #(
        .PIX_W(PIX_W)
    ) u_tx (
        .clk       (Clk),
        .rst       (Reset),
        .load      (load),
        .frame     (cap),
        .ready     (Out_ready),
        .busy      (busy),
        .out_data  (Out_data),
        .out_valid (Out_valid),
        .out_last  (Out_last),
        .frame_done(Frame_done)
    );

endmodule
